// File: rtl/lsu_datamem.sv
// Multicycle load/store unit between the CPU datapath and the synchronous data RAM.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors.
module lsu_datamem #(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] BASE_ADDR = 32'h10010000
) (
   input  logic              clockCPU,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_wren,
   output logic              mem_rden,
   input  logic [31:0]       mem_q
);

   typedef enum logic [2:0] {IDLE, RD, RDW, WR, DONE} state_t;

   state_t      state, state_next;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic        err_q;

   logic [31:0] offset;
   logic        accept;
   logic        legal;
   logic        misalign;
   logic        accept_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic [31:0] merged;

   assign offset = addr - BASE_ADDR;
   assign accept = (state == IDLE) && req;

   always_comb begin
      if (we) legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      else    legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      case (funct3[1:0])
         2'b01:   misalign = addr[0];
         2'b10:   misalign = (addr[1:0] != 2'b00);
         default: misalign = 1'b0;
      endcase
   end
`else
   // Low address bits below the access size are simply dropped.
   assign misalign = 1'b0;
`endif

   assign accept_err = !legal || misalign;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (accept_err)                       state_next = DONE;
               else if (we && funct3 == 3'b010)      state_next = WR;
               else                                  state_next = RD;
            end
         end
         RD:      state_next = RDW;
         RDW:     state_next = we_q ? WR : DONE;
         WR:      state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign byte_sel = 8'(mem_q >> {lane_q, 3'b000});
   assign half_sel = lane_q[1] ? mem_q[31:16] : mem_q[15:0];

   always_comb begin
      load_val = mem_q;
      merged   = mem_q;
      case (f3_q)
         3'b000: begin
            load_val                 = {{24{byte_sel[7]}}, byte_sel};
            merged[8*lane_q +: 8]    = wdata_q[7:0];
         end
         3'b001: begin
            load_val                 = {{16{half_sel[15]}}, half_sel};
            merged[16*lane_q[1] +: 16] = wdata_q[15:0];
         end
         3'b100:  load_val = {24'h0, byte_sel};
         3'b101:  load_val = {16'h0, half_sel};
         default: begin
            load_val = mem_q;
            merged   = wdata_q;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clockCPU or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         lane_q    <= 2'b00;
         wdata_q   <= 32'h0;
         err_q     <= 1'b0;
         rdata     <= 32'h0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
      end else begin
         state <= state_next;
         if (accept) begin
            we_q      <= we;
            f3_q      <= funct3;
            lane_q    <= addr[1:0];
            wdata_q   <= wdata;
            err_q     <= accept_err;
            mem_addr  <= offset[ADDR_W+1:2];
            mem_wdata <= wdata;
         end
         if (state == RDW) begin
            if (we_q) mem_wdata <= merged;
            else      rdata     <= load_val;
         end
      end
   end

   // Strobes decode straight from state, so an async reset kills a pending write at once.
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign err      = (state == DONE) && err_q;
   assign mem_rden = (state == RD);
   assign mem_wren = (state == WR);

endmodule

// File: tb/tb_lsu_datamem.sv
// Directed self-checking bench for lsu_datamem with a behavioural synchronous RAM.
module tb_lsu_datamem;

   localparam int          ADDR_W = 10;
   localparam logic [31:0] BASE   = 32'h10010000;

   logic              clockCPU = 1'b0;
   logic              reset;
   logic              req, we;
   logic [2:0]        funct3;
   logic [31:0]       addr, wdata;
   logic              busy, done, err;
   logic [31:0]       rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_q;
   logic              mem_wren, mem_rden;

   logic [31:0] ram [0:(1<<ADDR_W)-1];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clockCPU = ~clockCPU;

   lsu_datamem #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clockCPU(clockCPU), .reset(reset), .req(req), .we(we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
      .mem_rden(mem_rden), .mem_q(mem_q)
   );

   always @(posedge clockCPU) begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      if (mem_rden) mem_q <= ram[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, expv);
      end
   endtask

   // Issue one request; report the cycle done rose in and which cycles strobed the RAM.
   task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int done_cyc, output int wren_m,
                         output int rden_m, output logic err_o);
      done_cyc = -1; wren_m = 0; rden_m = 0; err_o = 1'bx;
      @(negedge clockCPU);
      req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
      @(posedge clockCPU);
      #1 req = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clockCPU);
         if (mem_wren) wren_m |= (1 << c);
         if (mem_rden) rden_m |= (1 << c);
         if (done) begin
            done_cyc = c;
            err_o    = err;
            break;
         end
      end
   endtask

   int   dc, wm, rm;
   logic eo;
   int   busy_low, done_cnt, wren_seen;

   initial begin
      reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
      @(negedge clockCPU);
      ram[0]    <= 32'h80FF7F01;
      ram[3]    <= 32'h11223344;
      ram[4]    <= 32'h55667788;
      ram[1023] <= 32'hCAFEF00D;
      @(negedge clockCPU);
      check("rst_busy",  32'(busy), 32'h0);
      check("rst_done",  32'(done), 32'h0);
      check("rst_err",   32'(err), 32'h0);
      check("rst_strobe", {30'h0, mem_wren, mem_rden}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_maddr", 32'(mem_addr), 32'h0);
      check("rst_mwdata", mem_wdata, 32'h0);
      reset = 1'b0;

      // Byte/half extraction from 80FF7F01
      access(1'b0, 3'b000, BASE + 1, 32'h0, dc, wm, rm, eo);
      check("lb1_cyc", 32'(dc), 32'd3);
      check("lb1_rden", 32'(rm), 32'h2);
      check("lb1_wren", 32'(wm), 32'h0);
      check("lb1_data", rdata, 32'h0000007F);
      access(1'b0, 3'b000, BASE + 2, 32'h0, dc, wm, rm, eo);
      check("lb2_data", rdata, 32'hFFFFFFFF);
      access(1'b0, 3'b100, BASE + 3, 32'h0, dc, wm, rm, eo);
      check("lbu3_data", rdata, 32'h00000080);
      access(1'b0, 3'b001, BASE + 2, 32'h0, dc, wm, rm, eo);
      check("lh2_data", rdata, 32'hFFFF80FF);
      access(1'b0, 3'b101, BASE + 0, 32'h0, dc, wm, rm, eo);
      check("lhu0_data", rdata, 32'h00007F01);
      check("lhu0_err", 32'(eo), 32'h0);

      // Full word store then load
      access(1'b1, 3'b010, BASE + 8, 32'hDEADBEEF, dc, wm, rm, eo);
      check("sw_cyc", 32'(dc), 32'd2);
      check("sw_wren", 32'(wm), 32'h2);
      check("sw_rden", 32'(rm), 32'h0);
      check("sw_ram", ram[2], 32'hDEADBEEF);
      access(1'b0, 3'b010, BASE + 8, 32'h0, dc, wm, rm, eo);
      check("lw_cyc", 32'(dc), 32'd3);
      check("lw_data", rdata, 32'hDEADBEEF);

      // Read-modify-write sub-word stores
      access(1'b1, 3'b000, BASE + 14, 32'h123456AA, dc, wm, rm, eo);
      check("sb_cyc", 32'(dc), 32'd4);
      check("sb_rden", 32'(rm), 32'h2);
      check("sb_wren", 32'(wm), 32'h8);
      check("sb_ram", ram[3], 32'h11AA3344);
      access(1'b1, 3'b001, BASE + 12, 32'h9999BEEF, dc, wm, rm, eo);
      check("sh_cyc", 32'(dc), 32'd4);
      check("sh_ram", ram[3], 32'h11AABEEF);

      // Index wrap modulo 2^ADDR_W, above and below the base
      access(1'b0, 3'b010, BASE + 32'd4096 + 32'd8, 32'h0, dc, wm, rm, eo);
      check("wrap_hi", rdata, 32'hDEADBEEF);
      access(1'b0, 3'b010, BASE - 32'd4, 32'h0, dc, wm, rm, eo);
      check("wrap_lo", rdata, 32'hCAFEF00D);

      // Reset asserted during RDW of an SB aborts with no write
      @(negedge clockCPU);
      req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = BASE + 16; wdata = 32'h000000EE;
      @(posedge clockCPU);
      #1 req = 1'b0;
      wren_seen = 0;
      @(negedge clockCPU);
      if (mem_wren) wren_seen++;
      @(negedge clockCPU);
      if (mem_wren) wren_seen++;
      reset = 1'b1;
      #1 check("abort_busy", 32'(busy), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clockCPU);
         if (mem_wren) wren_seen++;
      end
      reset = 1'b0;
      check("abort_wren", 32'(wren_seen), 32'h0);
      check("abort_ram", ram[4], 32'h55667788);
      check("abort_rdata", rdata, 32'h0);

      // Illegal funct3 completes in one cycle with no RAM access
      access(1'b0, 3'b010, BASE + 8, 32'h0, dc, wm, rm, eo);
      check("pre_ill_data", rdata, 32'hDEADBEEF);
      access(1'b0, 3'b011, BASE + 0, 32'h0, dc, wm, rm, eo);
      check("ill_ld_cyc", 32'(dc), 32'd1);
      check("ill_ld_err", 32'(eo), 32'h1);
      check("ill_ld_strobe", 32'(wm | rm), 32'h0);
      check("ill_ld_rdata", rdata, 32'hDEADBEEF);
      access(1'b1, 3'b100, BASE + 8, 32'h0BADF00D, dc, wm, rm, eo);
      check("ill_st_cyc", 32'(dc), 32'd1);
      check("ill_st_err", 32'(eo), 32'h1);
      check("ill_st_strobe", 32'(wm | rm), 32'h0);
      check("ill_st_ram", ram[2], 32'hDEADBEEF);

      // Misaligned word load
      access(1'b0, 3'b010, BASE + 2, 32'h0, dc, wm, rm, eo);
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis_cyc", 32'(dc), 32'd1);
      check("mis_err", 32'(eo), 32'h1);
      check("mis_rdata", rdata, 32'hDEADBEEF);
`else
      check("mis_cyc", 32'(dc), 32'd3);
      check("mis_err", 32'(eo), 32'h0);
      check("mis_rdata", rdata, 32'h80FF7F01);
`endif

      // req held high: accepts every 4 cycles, busy low only in those cycles
      @(negedge clockCPU);
      req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = BASE + 8;
      busy_low = 0; done_cnt = 0;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) @(negedge clockCPU);
         if (!busy) busy_low |= (1 << c);
         if (done) done_cnt++;
         if (c == 12) req = 1'b0;
      end
      check("b2b_busy_low", 32'(busy_low), 32'h00001111);
      check("b2b_done_cnt", 32'(done_cnt), 32'd3);
      check("b2b_data", rdata, 32'hDEADBEEF);

      repeat (6) @(negedge clockCPU);
      check("final_idle", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_datamem.md
Name: lsu_datamem

Overview:
- Multicycle load/store unit between the CPU datapath (ALU result / register read port 2) and the data RAM (ramD).
- Handles LB/LH/LW/LBU/LHU and SB/SH/SW:
  - byte/half extraction with sign or zero extension on loads;
  - read-modify-write merging on sub-word stores.
- Presents a busy/done handshake so the CPU can stall.
- Sits directly downstream of the CPU's ALU address path and upstream of the data memory.

Parameters:
- ADDR_W, 10, word-address width driven to the RAM; the byte address uses bits [ADDR_W+1:2].
- BASE_ADDR, 32'h10010000, start of the data segment; subtracted from the incoming address before indexing.

Ports:
- clockCPU  in  1  CPU clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; sampled with req.
- funct3  in  3  RISC-V funct3 of the load/store; sampled with req.
- addr  in  32  byte address (ALU result); sampled with req.
- wdata  in  32  store data (rs2); sampled with req.
- busy  out  1  high whenever state != IDLE; CPU stalls its PC on it.
- done  out  1  one-cycle pulse at completion.
- rdata  out  32  extended load result; valid when done=1, held until the next load completes.
- err  out  1  illegal funct3 (or misalignment, see Optional Feature); pulses with done.
- mem_addr  out  ADDR_W  word index to the RAM.
- mem_wdata  out  32  word to write.
- mem_wren  out  1  RAM write enable.
- mem_rden  out  1  RAM read enable.
- mem_q  in  32  RAM read data, valid one cycle after mem_rden.

Behaviour:
- Reset: state = IDLE; busy, done, err, mem_wren, mem_rden = 0; rdata, mem_addr, mem_wdata = 0.
  - Reset mid-operation aborts immediately; mem_wren drops asynchronously; no partial write completes.
- Request latching:
  - In IDLE with req = 1, the rising edge latches we, funct3, addr, wdata.
  - Word index = (addr - BASE_ADDR) >> 2, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - req is ignored while busy = 1.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else: state goes to DONE directly with err = 1, no RAM access, rdata unchanged.
- States: IDLE, RD, RDW, WR, DONE.
- Sequences (cycles after the accept edge):
  - Load: IDLE -> RD (mem_rden = 1, mem_addr driven) -> RDW (mem_q valid, captured and extended at end of cycle) -> DONE -> IDLE. done is high in cycle 3.
  - SW: IDLE -> WR (mem_wren = 1, mem_wdata = wdata) -> DONE -> IDLE. done is high in cycle 2.
  - SB/SH: IDLE -> RD -> RDW (mem_q merged with the byte/half lane chosen by addr[1:0]/addr[1]) -> WR (merged word written) -> DONE -> IDLE. done is high in cycle 4.
- Lane rules (little-endian):
  - Byte lane k = addr[1:0], bits [8k+7:8k].
  - Half lane = addr[1], bits [16h+15:16h].
  - Signed loads replicate the top bit of the lane; unsigned loads zero-fill.
- In DONE: done = 1 for exactly one cycle; busy = 1 during DONE, 0 the following cycle.
  - A new req is accepted on the first IDLE edge (back-to-back throughput: one access per 3, 4 or 5 cycles).
- mem_wren and mem_rden are never high in the same cycle, and are never high outside RD/WR.

Optional Feature:
- LSU_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0, go IDLE -> DONE with err = 1.
  - No RAM access; rdata unchanged.
- Undefined:
  - Misaligned low bits are ignored: halfword uses lane addr[1]; word ignores addr[1:0].
  - err only flags illegal funct3.

Test Plan:
- Preload word 0 = 32'h80FF7F01; LB @BASE+1 -> done in cycle 3, rdata = 32'h0000007F. LB @BASE+2 -> 32'hFFFFFFFF. LBU @BASE+3 -> 32'h00000080.
- SW 32'hDEADBEEF @BASE+8 -> mem_wren in cycle 1 only, done in cycle 2; a following LW @BASE+8 returns 32'hDEADBEEF.
- Word = 32'h11223344; SB 8'hAA @BASE+2 -> RD, RDW, WR sequence, written word 32'h11AA3344. Then SH 16'hBEEF @BASE+0 -> word 32'h11AABEEF.
- Assert reset during the RDW of an SB -> busy = 0, mem_wren never asserted, memory word unchanged.
- funct3 = 011 with req -> done and err in cycle 1, no mem_rden/mem_wren. With LSU_MISALIGN_TRAP_EN, LW @BASE+2 -> err = 1; without it, LW @BASE+2 returns word 0.
- Hold req high continuously with LW -> accepts spaced exactly 4 cycles apart (3-cycle access plus IDLE); busy low only on accept cycles.
